// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: a write of a page number to 16'h4014 halts the CPU and copies that page into OAM through the PPU register port.
// Optional build macro OAM_DMA_ODD_ALIGN_EN adds one extra alignment cycle when the trigger lands on an odd clock.
module ppu_oam_dma (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cpu_wr_stb_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  output logic        dma_active_out,
  output logic [15:0] dma_a_out,
  output logic        dma_r_nw_out,
  output logic [2:0]  ri_sel_out,
  output logic        ri_ncs_out,
  output logic        ri_r_nw_out,
  output logic [7:0]  ri_d_out
);

  localparam int unsigned PageW = 8;
  localparam int unsigned CntW  = 8;
  localparam int unsigned AddrW = PageW + CntW;

  localparam logic [15:0]     TrigAddr = 16'h4014;
  localparam logic [2:0]      OamData  = 3'h4;
  localparam logic [CntW-1:0] LastCnt  = 8'hFF;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAlign  = 3'd1;
  localparam logic [2:0] StRdAddr = 3'd2;
  localparam logic [2:0] StRdData = 3'd3;
  localparam logic [2:0] StWr     = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PageW-1:0] page_q, page_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       buf_q, buf_d;

  logic             rdy_q, rdy_d;
  logic             active_q, active_d;
  logic [AddrW-1:0] dma_a_q, dma_a_d;
  logic [2:0]       ri_sel_q, ri_sel_d;
  logic             ri_ncs_q, ri_ncs_d;
  logic             ri_r_nw_q, ri_r_nw_d;
  logic [7:0]       ri_d_q, ri_d_d;

  logic             trigger_c;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic parity_q;
  logic extra_q, extra_d;
`endif

  assign trigger_c = cpu_wr_stb_in && (cpu_a_in == TrigAddr);

  // Next-state logic; outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef OAM_DMA_ODD_ALIGN_EN
    extra_d = extra_q;
`endif
    case (state_q)
      StIdle: begin
        if (trigger_c) begin
          page_d  = cpu_d_in;
          cnt_d   = '0;
          state_d = StAlign;
`ifdef OAM_DMA_ODD_ALIGN_EN
          extra_d = parity_q;
`endif
        end
      end
      StAlign: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
        if (extra_q) begin
          extra_d = 1'b0;
        end else begin
          state_d = StRdAddr;
        end
`else
        state_d = StRdAddr;
`endif
      end
      StRdAddr: state_d = StRdData;
      StRdData: begin
        buf_d   = cpu_d_in;
        state_d = StWr;
      end
      StWr: begin
        cnt_d   = CntW'(cnt_q + 1'b1);
        state_d = (cnt_q == LastCnt) ? StIdle : StRdAddr;
      end
      default: state_d = StIdle;
    endcase

    active_d  = (state_d != StIdle);
    rdy_d     = ~active_d;
    ri_sel_d  = active_d ? OamData : 3'h0;
    ri_r_nw_d = ~active_d;
    ri_ncs_d  = (state_d != StWr);
    dma_a_d   = (state_d == StRdAddr) ? {page_d, cnt_d} : dma_a_q;
    ri_d_d    = (state_d == StWr) ? buf_d : ri_d_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      page_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      rdy_q     <= 1'b1;
      active_q  <= 1'b0;
      dma_a_q   <= '0;
      ri_sel_q  <= 3'h0;
      ri_ncs_q  <= 1'b1;
      ri_r_nw_q <= 1'b1;
      ri_d_q    <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      rdy_q     <= rdy_d;
      active_q  <= active_d;
      dma_a_q   <= dma_a_d;
      ri_sel_q  <= ri_sel_d;
      ri_ncs_q  <= ri_ncs_d;
      ri_r_nw_q <= ri_r_nw_d;
      ri_d_q    <= ri_d_d;
    end
  end

`ifdef OAM_DMA_ODD_ALIGN_EN
  // Free-running clock parity; decides whether ALIGN needs its second cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      parity_q <= 1'b0;
      extra_q  <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      extra_q  <= extra_d;
    end
  end
`endif

  assign cpu_rdy_out    = rdy_q;
  assign dma_active_out = active_q;
  assign dma_a_out      = dma_a_q;
  assign dma_r_nw_out   = 1'b1;
  assign ri_sel_out     = ri_sel_q;
  assign ri_ncs_out     = ri_ncs_q;
  assign ri_r_nw_out    = ri_r_nw_q;
  assign ri_d_out       = ri_d_q;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Randomized bench for ppu_oam_dma against a memory/OAM-write reference model.
module tb_ppu_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [15:0] addr;
  logic [7:0]  wdat;
  logic [7:0]  cpu_d;
  logic        rdy, active, dma_r_nw, ncs, ri_r_nw;
  logic [15:0] dma_a;
  logic [2:0]  sel;
  logic [7:0]  ri_d;

  logic [7:0]  mem [0:65535];
  logic [7:0]  mem_rd_q;
  int unsigned par_n;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ppu_oam_dma dut (
    .clk_in(clk), .rst_in(rst), .cpu_wr_stb_in(stb), .cpu_a_in(addr), .cpu_d_in(cpu_d),
    .cpu_rdy_out(rdy), .dma_active_out(active), .dma_a_out(dma_a), .dma_r_nw_out(dma_r_nw),
    .ri_sel_out(sel), .ri_ncs_out(ncs), .ri_r_nw_out(ri_r_nw), .ri_d_out(ri_d)
  );

  // Memory with one cycle of read latency; DMA owns the data bus while active.
  always @(posedge clk) mem_rd_q <= mem[dma_a];
  assign cpu_d = active ? mem_rd_q : wdat;

  // Count of clocks since reset release, for the odd-alignment expectation.
  always @(posedge clk) begin
    if (rst) par_n <= 0;
    else     par_n <= par_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 plain, 1 retrigger at byte 100, 2 trigger during final WR, 3 reset at byte 37
  task automatic run_dma(input logic [7:0] p, input int mode);
    int halt, pulses, highs, align, post;
    bit zero_acc;
    halt = 0; pulses = 0; highs = 0; zero_acc = 0;
    @(negedge clk);
    align = 1;
`ifdef OAM_DMA_ODD_ALIGN_EN
    if (par_n[0]) align = 2;
`endif
    stb = 1'b1; addr = 16'h4014; wdat = p;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      stb = 1'b0; wdat = 8'h00;
      if (rdy) break;
      halt++;
      if (halt > align && dma_a == 16'h0000 && p != 8'h00) zero_acc = 1;
      if (!ncs) begin
        chk("pulse_sel", 32'(sel), 32'h4);
        chk("pulse_rnw", 32'(ri_r_nw), 32'h0);
        chk("pulse_addr", 32'(dma_a), 32'({p, 8'(pulses)}));
        chk("pulse_data", 32'(ri_d), 32'(mem[{p, 8'(pulses)}]));
        if (pulses > 0) chk("pulse_gap", 32'(highs), 32'd2);
        pulses++;
        highs = 0;
        if (mode == 1 && pulses == 100) begin
          stb = 1'b1; addr = 16'h4014; wdat = ~p;
        end
        if (mode == 2 && pulses == 256) begin
          stb = 1'b1; addr = 16'h4014; wdat = 8'(p + 8'd1);
        end
        if (mode == 3 && pulses == 37) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst_rdy", 32'(rdy), 32'h1);
          chk("rst_ncs", 32'(ncs), 32'h1);
          chk("rst_active", 32'(active), 32'h0);
          chk("rst_dma_a", 32'(dma_a), 32'h0);
          chk("rst_ri_d", 32'(ri_d), 32'h0);
          rst = 1'b0;
          post = 0;
          repeat (40) begin
            @(negedge clk);
            if (!ncs || !rdy) post++;
          end
          chk("rst_no_resume", 32'(post), 32'h0);
          return;
        end
      end else begin
        highs++;
      end
    end
    stb = 1'b0;
    chk("halt_cycles", 32'(halt), 32'(768 + align));
    chk("pulse_count", 32'(pulses), 32'd256);
    chk("no_zero_access", 32'(zero_acc), 32'h0);
    chk("last_addr", 32'(dma_a), 32'({p, 8'hFF}));
    if (mode == 2) begin
      post = 0;
      repeat (6) begin
        @(negedge clk);
        if (!rdy || active) post++;
      end
      chk("final_wr_trigger_ignored", 32'(post), 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; addr = 16'h0000; wdat = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(rdy), 32'h1);
    chk("reset_active", 32'(active), 32'h0);
    chk("reset_dma_a", 32'(dma_a), 32'h0);
    chk("reset_dma_rnw", 32'(dma_r_nw), 32'h1);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_ncs", 32'(ncs), 32'h1);
    chk("reset_ri_rnw", 32'(ri_r_nw), 32'h1);
    chk("reset_ri_d", 32'(ri_d), 32'h0);
    rst = 1'b0;

    // Writes to neighbouring registers must not start a transfer.
    stb = 1'b1; addr = 16'h4015; wdat = 8'h02;
    @(negedge clk);
    addr = 16'h2004;
    @(negedge clk);
    stb = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("other_addr_rdy", 32'(rdy), 32'h1);
      chk("other_addr_active", 32'(active), 32'h0);
    end

    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    run_dma(8'h02, 0);
    run_dma(8'hFF, 0);
    run_dma(8'($urandom_range(1, 254)), 1);
    run_dma(8'($urandom_range(1, 254)), 2);
    run_dma(8'($urandom_range(1, 254)), 3);
    for (int t = 0; t < 3; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_dma(8'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_oam_dma.md
PPU_OAM_DMA -- requirements
Module: ppu_oam_dma

Interface
REQ-001 SHALL have one clock and one reset: clk_in, a single clock; rst_in, synchronous and active-high.
REQ-002 clk_in  input  1  system clock.
REQ-003 rst_in  input  1  synchronous active-high reset.
REQ-004 cpu_wr_stb_in  input  1  single-cycle CPU bus write strobe.
REQ-005 cpu_a_in  input  16  CPU write address, qualified by cpu_wr_stb_in.
REQ-006 cpu_d_in  input  8  CPU write data when strobed; memory read data during DMA, valid 1 cycle after dma_a_out.
REQ-007 cpu_rdy_out  output  1  0 = CPU halted; DMA owns the bus.
REQ-008 dma_active_out  output  1  1 while the DMA is in any state other than IDLE; selects the DMA onto the CPU bus and PPU register port.
REQ-009 dma_a_out  output  16  DMA memory read address.
REQ-010 dma_r_nw_out  output  1  1 = read; constant 1.
REQ-011 ri_sel_out  output  3  PPU register select: 3'h4 when active, 3'h0 otherwise.
REQ-012 ri_ncs_out  output  1  PPU register chip select, active low.
REQ-013 ri_r_nw_out  output  1  PPU register read/write select: 0 while active, 1 otherwise.
REQ-014 ri_d_out  output  8  PPU register write data.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 Trigger: cpu_wr_stb_in=1 with cpu_a_in==16'h4014 in IDLE SHALL latch cpu_d_in as page[7:0], clear byte counter cnt[7:0], and enter ALIGN.
REQ-017 A trigger while not in IDLE SHALL be ignored; the page and counter SHALL be unchanged.
REQ-018 Writes to any other address SHALL be ignored.
REQ-019 States: IDLE, ALIGN, RD_ADDR, RD_DATA, WR.
  - IDLE->ALIGN on trigger.
  - ALIGN->RD_ADDR.
  - RD_ADDR->RD_DATA.
  - RD_DATA->WR.
  - WR->RD_ADDR if cnt!=8'hFF.
  - WR->IDLE if cnt==8'hFF.
REQ-020 cpu_rdy_out SHALL be 0 in the cycle after the trigger cycle and SHALL stay 0 until the cycle after the final WR.
REQ-021 RD_ADDR: dma_a_out SHALL be {page, cnt}.
REQ-022 RD_DATA: cpu_d_in SHALL be captured into the byte buffer.
REQ-023 WR: ri_d_out SHALL be the byte buffer and ri_ncs_out SHALL be 0, for exactly one cycle; cnt SHALL increment mod 256 at WR exit.
REQ-024 ri_ncs_out SHALL be 1 in every state except WR, giving one falling edge per byte with at least 2 high cycles between edges.
REQ-025 A transfer SHALL be exactly 256 WR pulses, with bytes taken from addresses {page,8'h00} through {page,8'hFF} in ascending order.
REQ-026 Base latency from trigger to IDLE SHALL be 1 (ALIGN) + 768 cycles.
REQ-027 Page 8'hFF SHALL read 16'hFF00-16'hFFFF with no carry into the page.
REQ-028 A trigger in the same cycle as the final WR SHALL be ignored; IDLE SHALL be reached first.

Reset
REQ-029 rst_in SHALL force, on the next edge, from any state including mid-transfer:
  - state=IDLE, cnt=0, page=0, buffer=0, cycle parity=0;
  - cpu_rdy_out=1, dma_active_out=0, dma_a_out=0, dma_r_nw_out=1;
  - ri_sel_out=0, ri_ncs_out=1, ri_r_nw_out=1, ri_d_out=0.
REQ-030 A transfer interrupted by reset SHALL NOT resume; OAM contents already written SHALL remain.

Configuration
REQ-031 Macro OAM_DMA_ODD_ALIGN_EN:
  - Defined: an internal parity bit SHALL toggle every clock after reset. A trigger sampled with parity=1 SHALL spend 2 cycles in ALIGN; parity=0 SHALL spend 1 cycle.
  - Undefined: ALIGN SHALL always be 1 cycle and no parity register SHALL exist.

Verification
REQ-032 Write 16'h4014<-8'h02, memory[16'h0200+i]=i^8'h5A:
  - 256 ri_ncs_out low pulses with ri_sel_out=4 and ri_d_out=i^8'h5A in order;
  - cpu_rdy_out low for 769 cycles.
REQ-033 Page 8'hFF -> last read address 16'hFFFF; first address 16'hFF00; no access to 16'h0000.
REQ-034 Second write to 16'h4014 at byte 100 -> ignored; 256 total pulses; page unchanged.
REQ-035 rst_in asserted at byte 37 -> next cycle: IDLE, cpu_rdy_out=1, ri_ncs_out=1; no further pulses.
REQ-036 OAM_DMA_ODD_ALIGN_EN defined, trigger on odd parity -> first RD_ADDR 3 cycles after trigger, 770-cycle halt; even parity -> 769-cycle halt.
REQ-037 Write to 16'h4015 or 16'h2004 -> no state change; cpu_rdy_out stays 1.
